// File: rtl/noc_rr_outport_arbiter.sv
// noc_rr_outport_arbiter: packet-locking round-robin arbiter for one router output port (L,N,E,W,S).
// Define ARB_TIMEOUT_EN to build the per-packet timeout that force-releases a stalled lock.
module noc_rr_outport_arbiter #(
   parameter int CNT_W = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         req_i,
   input  logic [14:0]        flit_id_i,
   input  logic [5*CNT_W-1:0] length_i,
   input  logic               out_ready_i,
   output logic [4:0]         grant_o,
   output logic               xfer_o,
   output logic               busy_o,
   output logic               timeout_o
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state_q, state_d;
   logic [4:0] grant_q, grant_d, elig, tails;
   logic [2:0] ptr_q, ptr_d, win, gidx, nxt;
   logic [3:0] sum;
   logic found, release_ev, to_ev, timeout_q, timeout_d;

   always_comb begin
      elig = '0;
      tails = '0;
      for (int i = 0; i < 5; i++) begin
         elig[i] = req_i[i] & flit_id_i[3*i];
         tails[i] = flit_id_i[3*i+2];
      end
   end

   // scan from the far end so the input nearest ptr overwrites the rest
   always_comb begin
      win = ptr_q;
      found = 1'b0;
      sum = '0;
      for (int k = 4; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + 4'(k);
         if (sum > 4'd4) sum = sum - 4'd5;
         if (elig[sum[2:0]]) begin
            win = sum[2:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < 5; i++) if (grant_q[i]) gidx = 3'(i);
   end

   assign nxt = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
   assign xfer_o = |(grant_q & req_i) & out_ready_i;
   assign release_ev = xfer_o & |(grant_q & tails);
   assign busy_o = state_q == LOCKED;
   assign grant_o = grant_q;
   assign timeout_o = timeout_q;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] count_q, count_d, limit_q, limit_d, len_win;

   always_comb begin
      len_win = '0;
      for (int i = 0; i < 5; i++) if (win == 3'(i)) len_win = length_i[i*CNT_W +: CNT_W];
   end

   assign count_d = (state_q == IDLE) ? '0 : (&count_q ? count_q : count_q + CNT_W'(1));
   assign limit_d = (state_q == IDLE && found) ? len_win : limit_q;
   assign to_ev = busy_o && limit_q != '0 && count_q == limit_q - CNT_W'(1) && !release_ev;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         limit_q <= '0;
      end else begin
         count_q <= count_d;
         limit_q <= limit_d;
      end
   end
`else
   logic unused_len;
   assign unused_len = ^length_i;
   assign to_ev = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d = ptr_q;
      timeout_d = 1'b0;
      if (state_q == IDLE) begin
         if (found) begin
            grant_d = 5'b00001 << win;
            state_d = LOCKED;
         end
      end else if (release_ev || to_ev) begin
         grant_d = '0;
         ptr_d = nxt;
         state_d = IDLE;
         timeout_d = to_ev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q <= ptr_d;
         timeout_q <= timeout_d;
      end
   end
endmodule

// File: tb/tb_noc_rr_outport_arbiter.sv
// tb_noc_rr_outport_arbiter: directed checks of grant, rotation, stalls, timeout and reset.
module tb_noc_rr_outport_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] req = '0;
   logic [2:0] ft [5];
   logic [11:0] len [5];
   logic ready = 1'b0;
   logic [14:0] flit_id;
   logic [59:0] length;
   logic [4:0] grant_o;
   logic xfer_o, busy_o, timeout_o;
   int n_chk = 0;
   int n_fail = 0;

   assign flit_id = {ft[4], ft[3], ft[2], ft[1], ft[0]};
   assign length = {len[4], len[3], len[2], len[1], len[0]};

   always #5 clk = ~clk;

   noc_rr_outport_arbiter #(.CNT_W(12)) dut (
      .clk(clk), .rst(rst), .req_i(req), .flit_id_i(flit_id), .length_i(length),
      .out_ready_i(ready), .grant_o(grant_o), .xfer_o(xfer_o), .busy_o(busy_o),
      .timeout_o(timeout_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 5; i++) begin
         ft[i] = '0;
         len[i] = '0;
      end
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 00000", grant_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      n_chk++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
      n_chk++; if (xfer_o !== 1'b0) begin n_fail++; $display("FAIL reset_xfer: got %b expected 0", xfer_o); end
      n_chk++; if (dut.ptr_q !== 3'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
   endtask

   task automatic test_single_flit_w;
      req = 5'b01000;
      ft[3] = 3'b101;
      ready = 1'b1;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL single_latency: got %b expected 00000", grant_o); end
      tick();
      n_chk++; if (grant_o !== 5'b01000) begin n_fail++; $display("FAIL single_grant: got %b expected 01000", grant_o); end
      n_chk++; if (xfer_o !== 1'b1) begin n_fail++; $display("FAIL single_xfer: got %b expected 1", xfer_o); end
      tick();
      req = '0;
      ft[3] = '0;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL single_release: got %b expected 00000", grant_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy_o); end
      n_chk++; if (dut.ptr_q !== 3'd4) begin n_fail++; $display("FAIL single_ptr: got %0d expected 4", dut.ptr_q); end
   endtask

   task automatic test_rotation;
      logic [4:0] exp;
      req = 5'b00111;
      for (int i = 0; i < 3; i++) ft[i] = 3'b001;
      ready = 1'b1;
      #1;
      tick();
      for (int p = 0; p < 3; p++) begin
         exp = 5'b00001 << p;
         for (int f = 0; f < 3; f++) begin
            ft[p] = (f == 0) ? 3'b001 : (f == 1) ? 3'b010 : 3'b100;
            #1;
            n_chk++; if (grant_o !== exp) begin n_fail++; $display("FAIL rot_grant p%0d f%0d: got %b expected %b", p, f, grant_o, exp); end
            n_chk++; if (xfer_o !== 1'b1) begin n_fail++; $display("FAIL rot_xfer p%0d f%0d: got %b expected 1", p, f, xfer_o); end
            tick();
         end
         req[p] = 1'b0;
         ft[p] = '0;
         #1;
         n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL rot_bubble p%0d: got %b expected 00000", p, grant_o); end
         tick();
      end
      n_chk++; if (dut.ptr_q !== 3'd3) begin n_fail++; $display("FAIL rot_ptr: got %0d expected 3", dut.ptr_q); end
   endtask

   task automatic test_stall_n;
      int sent = 0;
      req = 5'b00010;
      ft[1] = 3'b001;
      ready = 1'b1;
      #1;
      tick();
      for (int c = 0; c < 7; c++) begin
         ready = (c % 2 == 0);
         ft[1] = (sent == 0) ? 3'b001 : (sent == 3) ? 3'b100 : 3'b010;
         #1;
         n_chk++; if (grant_o !== 5'b00010) begin n_fail++; $display("FAIL stall_grant c%0d: got %b expected 00010", c, grant_o); end
         n_chk++; if (xfer_o !== ready) begin n_fail++; $display("FAIL stall_xfer c%0d: got %b expected %b", c, xfer_o, ready); end
         if (ready) sent++;
         tick();
      end
      req = '0;
      ft[1] = '0;
      ready = 1'b1;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 00000", grant_o); end
      n_chk++; if (dut.ptr_q !== 3'd2) begin n_fail++; $display("FAIL stall_ptr: got %0d expected 2", dut.ptr_q); end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout;
      req = 5'b10000;
      ft[4] = 3'b001;
      len[4] = 12'd8;
      ready = 1'b1;
      #1;
      tick();
      n_chk++; if (grant_o !== 5'b10000) begin n_fail++; $display("FAIL to_grant: got %b expected 10000", grant_o); end
      tick();
      req = '0;
      ft[4] = 3'b010;
      for (int k = 1; k < 8; k++) begin
         #1;
         n_chk++; if (grant_o !== 5'b10000) begin n_fail++; $display("FAIL to_hold k%0d: got %b expected 10000", k, grant_o); end
         n_chk++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_early k%0d: got %b expected 0", k, timeout_o); end
         tick();
      end
      n_chk++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b expected 1", timeout_o); end
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL to_release: got %b expected 00000", grant_o); end
      n_chk++; if (dut.ptr_q !== 3'd0) begin n_fail++; $display("FAIL to_ptr: got %0d expected 0", dut.ptr_q); end
      tick();
      n_chk++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_width: got %b expected 0", timeout_o); end
      ft[4] = '0;
      len[4] = '0;
   endtask
`endif

   task automatic test_long_stall;
`ifdef ARB_TIMEOUT_EN
      len[3] = 12'd0;
`else
      len[3] = 12'd3;
`endif
      req = 5'b01000;
      ft[3] = 3'b001;
      ready = 1'b1;
      #1;
      tick();
      n_chk++; if (grant_o !== 5'b01000) begin n_fail++; $display("FAIL long_grant: got %b expected 01000", grant_o); end
      tick();
      ft[3] = 3'b010;
      ready = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         #1;
         n_chk++;
         if (timeout_o !== 1'b0 || grant_o !== 5'b01000) begin
            n_fail++;
            $display("FAIL long_hold cycle %0d: got grant %b timeout %b expected 01000 0", i, grant_o, timeout_o);
            break;
         end
         tick();
      end
      ft[3] = 3'b100;
      ready = 1'b1;
      #1;
      n_chk++; if (xfer_o !== 1'b1) begin n_fail++; $display("FAIL long_tail_xfer: got %b expected 1", xfer_o); end
      tick();
      req = '0;
      ft[3] = '0;
      len[3] = '0;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL long_release: got %b expected 00000", grant_o); end
      n_chk++; if (dut.ptr_q !== 3'd4) begin n_fail++; $display("FAIL long_ptr: got %0d expected 4", dut.ptr_q); end
   endtask

   task automatic test_rst_mid;
      req = 5'b00100;
      ft[2] = 3'b001;
      ready = 1'b1;
      #1;
      tick();
      n_chk++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL rst_grant: got %b expected 00100", grant_o); end
      tick();
      ft[2] = 3'b010;
      ready = 1'b0;
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      #1;
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 00000", grant_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
      n_chk++; if (dut.ptr_q !== 3'd0) begin n_fail++; $display("FAIL rst_mid_ptr: got %0d expected 0", dut.ptr_q); end
      n_chk++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_timeout: got %b expected 0", timeout_o); end
      ready = 1'b1;
      #1;
      tick();
      n_chk++; if (grant_o !== 5'b0) begin n_fail++; $display("FAIL rst_body_grant: got %b expected 00000", grant_o); end
      n_chk++; if (xfer_o !== 1'b0) begin n_fail++; $display("FAIL rst_body_xfer: got %b expected 0", xfer_o); end
      req = '0;
      ft[2] = '0;
   endtask

   initial begin
      test_reset();
      test_single_flit_w();
      test_rotation();
      test_stall_n();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_long_stall();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_rr_outport_arbiter.md
# noc_rr_outport_arbiter

Packet-locking round-robin arbiter for one router output port, shared by the five input ports (L, N, E, W, S). It grants the output to one input from header flit to tail flit, rotates priority fairly between packets, and releases a stalled packet through a per-packet timeout. One instance sits in front of each output-port crossbar mux; its one-hot grant drives the mux select.

## Interface
- `CNT_W`, default 12: width of the timeout counter and of each `length` field.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `req` input 5: per-input request; bit 0=L, 1=N, 2=E, 3=W, 4=S.
- `flit_id` input 15: packed 3-bit flit type per input, `[3i+2:3i]`. Bit 0 is header, bit 1 is body, bit 2 is tail. `3'b101` is a single-flit packet.
- `length` input 5*CNT_W: packed per-input timeout budget in cycles, sampled at grant.
- `out_ready` input 1: downstream can accept a flit this cycle.
- `grant` output 5: one-hot selected input; all zero when idle.
- `xfer` output 1: a flit moves this cycle, `|(grant & req) & out_ready`.
- `busy` output 1: the arbiter is in the LOCKED state.
- `timeout` output 1: one-cycle pulse when a packet is force-released.

## Operation
- The FSM has two states, IDLE and LOCKED.
- Registered state: `state`, `grant`, 3-bit `ptr` (the highest-priority input, 0..4), `limit[CNT_W-1:0]` and `count[CNT_W-1:0]`.
- Eligible input i: `req[i]` is high and `flit_id[3i]` is high. Body and tail flits without an owning lock are never eligible.
- IDLE:
  - If any input is eligible, the winner is the first eligible input scanning `ptr`, `ptr+1`, … modulo 5.
  - Next cycle: grant = onehot(winner), `limit` = `length` of the winner, `count` = 0, state = LOCKED.
  - If no input is eligible, stay in IDLE with grant = 0.
- LOCKED:
  - Grant is held regardless of other requests.
  - Releasing event: an `xfer` whose granted `flit_id` has bit 2 set.
  - On a releasing event: grant = 0, `ptr` = (winner+1) mod 5, state = IDLE.
  - If the granted `req` drops mid-packet, the lock is held; only the tail or a timeout releases it.
- Timeout (macro enabled):
  - In LOCKED, `count` increments every cycle and saturates at all-ones.
  - When `limit` != 0 and `count` == `limit`-1 with no releasing event that cycle, the next cycle has grant = 0, `ptr` = winner+1, state = IDLE, and `timeout` = 1 for one cycle.
  - `limit` = 0 disables the timeout for that packet.
- `ptr` advances only on release, never while IDLE.

## Timing
- Reset values: state = IDLE, grant = 0, `ptr` = 0 (L highest priority), `count` = 0, `limit` = 0, `busy` = 0, `timeout` = 0, `xfer` = 0.
- `rst` mid-packet clears the lock on the next edge; no `timeout` pulse is generated.
- Arbitration latency is 1 cycle: an eligible header in cycle N gives grant in N+1.
- The header can transfer in N+1 if `out_ready` is high.
- After release there is one idle bubble cycle before the next grant; back-to-back grants to the same input are allowed if it alone is eligible.
- A tail `xfer` and a timeout in the same cycle count as a normal release: `timeout` = 0.
- `xfer` is combinational from registered grant and the live `req`/`out_ready`; there is no combinational path from `length`.
- Simultaneous headers on all five inputs: the ptr-first input wins, and successive packets are served in rotation L→N→E→W→S→L.
- `ptr` wraps 4→0.

## Configuration
- `ARB_TIMEOUT_EN`:
  - Defined: the `count`/`limit` logic and the timeout release above are built.
  - Undefined: no counter or `limit` registers are built, `timeout` is tied to 0, `length` is ignored, and only a tail releases a lock.

## Test plan
- Reset, then a single-flit header (`3'b101`) on W with `out_ready`=1: grant = `5'b01000` one cycle later, one `xfer`, grant returns to 0 and `ptr` = 4.
- L, N and E present headers together and each sends a 3-flit packet (header, body, tail): grants in order L, N, E with one idle cycle between packets; `ptr` ends at 3.
- N granted with 4 flits and `out_ready` toggling 1,0,1,0…: `xfer` is high only when ready; the lock holds through stalls and releases after the 4th `xfer`.
- `ARB_TIMEOUT_EN` defined, S granted with `length`=8, header sent, then `req[4]` dropped: `timeout` pulses 8 cycles after grant; grant = 0 and `ptr` = 0.
- `length`=0 and a stalled packet for 5000 cycles: no `timeout` and the lock is held. With the macro undefined and `length`=3, the result is the same.
- `rst` asserted mid-packet while E is locked: next cycle grant = 0, `busy` = 0, `ptr` = 0, `timeout` = 0. A body flit on E afterwards is not granted.
